// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared constants, widths and the T20 period helper for the
//                Pong score/timer datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package pong_pkg;

    localparam int WIN_SCORE    = 5;
    localparam int LVL_MAX      = 7;
    localparam int HITS_PER_LVL = 4;
    localparam int SCORE_W      = 4;
    localparam int LVL_W        = 3;

    // Ball-step period in clocks for a given level. The caller guarantees
    // base > LVL_MAX*step so the result never reaches zero.
    function automatic int t20_period(input logic [LVL_W-1:0] lvl,
                                      input int base,
                                      input int step);
        return base - int'(lvl) * step;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_score_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pong_score_timer_if
//  Description : Strobe/status bundle between the Pong controller (master)
//                and the score/timer datapath (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface pong_score_timer_if;
    import pong_pkg::*;

    // Controller strobes
    logic               T5_en;
    logic               T20_en;
    logic               Hit_ld;
    logic               Hit_clr;
    logic               Lvl_clr;
    logic               P1_ld;
    logic               P1_clr;
    logic               P2_ld;
    logic               P2_clr;

    // Datapath status back to controller / display
    logic               T5_out;
    logic               T20_out;
    logic               winner;
    logic               winner_id;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [LVL_W-1:0]   level;

    modport master (
        output T5_en, T20_en, Hit_ld, Hit_clr, Lvl_clr,
               P1_ld, P1_clr, P2_ld, P2_clr,
        input  T5_out, T20_out, winner, winner_id,
               p1_score, p2_score, level
    );

    modport slave (
        input  T5_en, T20_en, Hit_ld, Hit_clr, Lvl_clr,
               P1_ld, P1_clr, P2_ld, P2_clr,
        output T5_out, T20_out, winner, winner_id,
               p1_score, p2_score, level
    );

endinterface
`default_nettype wire

// File: rtl/pong_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pong_timer
//  Description : Enable-gated modulo counter. Advances on i_inc, emits a
//                one-clock pulse when the count would reach i_limit and then
//                restarts at zero. Dropping i_en clears count and pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module pong_timer #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             i_en,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_pulse
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_pulse;
    logic [WIDTH:0]   w_next;
    logic             w_term;

    // Compare with >= so a limit that shrinks below the running count
    // terminates on the very next increment instead of wrapping.
    assign w_next  = {1'b0, r_cnt} + (WIDTH+1)'(1);
    assign w_term  = (w_next >= {1'b0, i_limit});
    assign o_pulse = r_pulse;

    // Count register and registered terminal-count pulse
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (i_inc) begin
            if (w_term) begin
                r_cnt   <= '0;
                r_pulse <= 1'b1;
            end else begin
                r_cnt   <= w_next[WIDTH-1:0];
                r_pulse <= 1'b0;
            end
        end else begin
            r_pulse <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pong_score_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pong_score_timer
//  Description : Pong datapath: T5 serve/pause timer with prescaler, T20
//                level-dependent ball-step timer, hit counter and level,
//                per-player scores and registered winner flags.
//                T20_BASE must exceed LVL_MAX*T20_STEP.
//  Revision    : 1.0  initial release
// ============================================================================
module pong_score_timer #(
    parameter int TICK_DIV     = 4,
    parameter int T5_TICKS     = 5,
    parameter int T20_BASE     = 20,
    parameter int T20_STEP     = 2,
    parameter int HITS_PER_LVL = pong_pkg::HITS_PER_LVL,
    parameter int LVL_MAX      = pong_pkg::LVL_MAX,
    parameter int WIN_SCORE    = pong_pkg::WIN_SCORE
) (
    input  logic              Clk,
    input  logic              Rst_n,
    pong_score_timer_if.slave bus
);
    import pong_pkg::*;

    localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_HIT_W = (HITS_PER_LVL > 1) ? $clog2(HITS_PER_LVL) : 1;
    localparam int c_T5_W  = $clog2(T5_TICKS + 1);
    localparam int c_T20_W = $clog2(T20_BASE + 1);

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
    localparam logic [c_HIT_W-1:0] c_HIT_LAST = c_HIT_W'(HITS_PER_LVL - 1);
    localparam logic [LVL_W-1:0]   c_LVL_MAX  = LVL_W'(LVL_MAX);
    localparam logic [SCORE_W-1:0] c_WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [c_T5_W-1:0]  c_T5_LIM   = c_T5_W'(T5_TICKS);

    logic [c_PRE_W-1:0] r_pre;
    logic               w_tick;
    logic [c_HIT_W-1:0] r_hit_cnt;
    logic [LVL_W-1:0]   r_level;
    logic [SCORE_W-1:0] r_p1_score;
    logic [SCORE_W-1:0] r_p2_score;
    logic               r_winner;
    logic               r_winner_id;
    logic [c_T20_W-1:0] w_t20_limit;
    logic               w_p1_won;
    logic               w_p2_won;

    // ------------------------------------------------------------------------
    // T5 path: prescaler restarts whenever T5 is disabled so the first
    // timeout after enable is exactly TICK_DIV*T5_TICKS clocks away.
    // ------------------------------------------------------------------------
    assign w_tick = bus.T5_en && (r_pre == c_PRE_LAST);

    // Free-running prescaler, held at zero while T5 is disabled
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pre <= '0;
        end else if (!bus.T5_en || (r_pre == c_PRE_LAST)) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    pong_timer #(
        .WIDTH   (c_T5_W)
    ) u_t5 (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .i_en    (bus.T5_en),
        .i_inc   (w_tick),
        .i_limit (c_T5_LIM),
        .o_pulse (bus.T5_out)
    );

    // ------------------------------------------------------------------------
    // T20 path: period follows the live level, so a level change shortens
    // the count already in progress.
    // ------------------------------------------------------------------------
    assign w_t20_limit = c_T20_W'(t20_period(r_level, T20_BASE, T20_STEP));

    pong_timer #(
        .WIDTH   (c_T20_W)
    ) u_t20 (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .i_en    (bus.T20_en),
        .i_inc   (1'b1),
        .i_limit (w_t20_limit),
        .o_pulse (bus.T20_out)
    );

    // ------------------------------------------------------------------------
    // Hit counter and level
    // ------------------------------------------------------------------------
    // Hits roll into level increments; clears take priority over loads
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_hit_cnt <= '0;
            r_level   <= '0;
        end else if (bus.Lvl_clr) begin
            r_hit_cnt <= '0;
            r_level   <= '0;
        end else if (bus.Hit_clr) begin
            r_hit_cnt <= '0;
        end else if (bus.Hit_ld) begin
            if (r_hit_cnt == c_HIT_LAST) begin
                r_hit_cnt <= '0;
                if (r_level < c_LVL_MAX) begin
                    r_level <= r_level + LVL_W'(1);
                end
            end else begin
                r_hit_cnt <= r_hit_cnt + c_HIT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scores and winner
    // ------------------------------------------------------------------------
    // Player 1 score, saturating at the winning score
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_p1_score <= '0;
        end else if (bus.P1_clr) begin
            r_p1_score <= '0;
        end else if (bus.P1_ld && (r_p1_score < c_WIN)) begin
            r_p1_score <= r_p1_score + SCORE_W'(1);
        end
    end

    // Player 2 score, saturating at the winning score
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_p2_score <= '0;
        end else if (bus.P2_clr) begin
            r_p2_score <= '0;
        end else if (bus.P2_ld && (r_p2_score < c_WIN)) begin
            r_p2_score <= r_p2_score + SCORE_W'(1);
        end
    end

    assign w_p1_won = (r_p1_score == c_WIN);
    assign w_p2_won = (r_p2_score == c_WIN);

    // Registered winner flags; a tie is credited to player 1
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_winner    <= 1'b0;
            r_winner_id <= 1'b0;
        end else begin
            r_winner    <= w_p1_won | w_p2_won;
            r_winner_id <= w_p2_won & ~w_p1_won;
        end
    end

    assign bus.winner    = r_winner;
    assign bus.winner_id = r_winner_id;
    assign bus.p1_score  = r_p1_score;
    assign bus.p2_score  = r_p2_score;
    assign bus.level     = r_level;

endmodule
`default_nettype wire

// File: tb/tb_pong_score_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_score_timer
//  Description : Directed self-checking bench for pong_score_timer.
//                Inputs change on the falling edge, outputs are sampled on
//                the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pong_score_timer;
    import pong_pkg::*;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    pong_score_timer_if bus ();

    pong_score_timer #(
        .TICK_DIV     (4),
        .T5_TICKS     (5),
        .T20_BASE     (20),
        .T20_STEP     (2),
        .HITS_PER_LVL (4),
        .LVL_MAX      (7),
        .WIN_SCORE    (5)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic idle_inputs();
        bus.T5_en   = 1'b0;
        bus.T20_en  = 1'b0;
        bus.Hit_ld  = 1'b0;
        bus.Hit_clr = 1'b0;
        bus.Lvl_clr = 1'b0;
        bus.P1_ld   = 1'b0;
        bus.P1_clr  = 1'b0;
        bus.P2_ld   = 1'b0;
        bus.P2_clr  = 1'b0;
    endtask

    // n consecutive one-cycle strobes on the selected loads
    task automatic strobe(input int n, input bit hit, input bit p1, input bit p2);
        for (int i = 0; i < n; i++) begin
            bus.Hit_ld = hit;
            bus.P1_ld  = p1;
            bus.P2_ld  = p2;
            @(negedge Clk);
            bus.Hit_ld = 1'b0;
            bus.P1_ld  = 1'b0;
            bus.P2_ld  = 1'b0;
        end
    endtask

    // Sample one timer output for ncyc falling edges, recording pulse positions
    task automatic measure(input bit use_t20, input int ncyc,
                           output int cnt, output int first, output int second);
        cnt = 0; first = -1; second = -1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge Clk);
            if ((use_t20 ? bus.T20_out : bus.T5_out) === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
    endtask

    task automatic test_reset();
        logic [16:0] outs;
        idle_inputs();
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        outs = {bus.T5_out, bus.T20_out, bus.winner, bus.winner_id,
                bus.p1_score, bus.p2_score, bus.level};
        n_tests++;
        if (outs !== 17'd0) begin
            n_fail++; $display("FAIL reset_state: got %h expected 0", outs);
        end
        Rst_n = 1'b1;
        @(negedge Clk);
        bus.T5_en = 1'b1;
        strobe(3, 1'b0, 1'b1, 1'b1);
        strobe(4, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.p1_score !== 4'd3 || bus.p2_score !== 4'd3 || bus.level !== 3'd1) begin
            n_fail++; $display("FAIL pre_reset_values: got p1=%0d p2=%0d lvl=%0d expected 3 3 1",
                               bus.p1_score, bus.p2_score, bus.level);
        end
        #2 Rst_n = 1'b0;
        #1;
        outs = {bus.T5_out, bus.T20_out, bus.winner, bus.winner_id,
                bus.p1_score, bus.p2_score, bus.level};
        n_tests++;
        if (outs !== 17'd0) begin
            n_fail++; $display("FAIL async_reset: got %h expected 0 before next edge", outs);
        end
        @(negedge Clk);
        idle_inputs();
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_t5();
        int c, f, s, c2, f2, s2;
        bus.T5_en = 1'b1;
        measure(1'b0, 40, c, f, s);
        n_tests++;
        if (c != 2 || f != 20 || s != 40) begin
            n_fail++; $display("FAIL t5_period: got cnt=%0d at %0d,%0d expected 2 at 20,40", c, f, s);
        end
        bus.T5_en = 1'b0;
        @(negedge Clk);
        bus.T5_en = 1'b1;
        measure(1'b0, 30, c, f, s);
        bus.T5_en = 1'b0;
        measure(1'b0, 15, c2, f2, s2);
        n_tests++;
        if (c != 1 || f != 20 || c2 != 0) begin
            n_fail++; $display("FAIL t5_disable: got cnt=%0d first=%0d after=%0d expected 1 20 0", c, f, c2);
        end
    endtask

    task automatic test_level();
        int c, f, s;
        strobe(3, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.level !== 3'd0) begin
            n_fail++; $display("FAIL level_3_hits: got %0d expected 0", bus.level);
        end
        strobe(1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.level !== 3'd1) begin
            n_fail++; $display("FAIL level_4_hits: got %0d expected 1", bus.level);
        end
        bus.T20_en = 1'b1;
        measure(1'b1, 40, c, f, s);
        bus.T20_en = 1'b0;
        n_tests++;
        if (c != 2 || f != 18 || s != 36) begin
            n_fail++; $display("FAIL t20_level1: got cnt=%0d at %0d,%0d expected 2 at 18,36", c, f, s);
        end
        strobe(24, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.level !== 3'd7) begin
            n_fail++; $display("FAIL level_reach_max: got %0d expected 7", bus.level);
        end
        strobe(4, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.level !== 3'd7) begin
            n_fail++; $display("FAIL level_saturate: got %0d expected 7", bus.level);
        end
        bus.T20_en = 1'b1;
        measure(1'b1, 20, c, f, s);
        bus.T20_en = 1'b0;
        n_tests++;
        if (c != 3 || f != 6 || s != 12) begin
            n_fail++; $display("FAIL t20_level7: got cnt=%0d at %0d,%0d expected 3 at 6,12", c, f, s);
        end
    endtask

    task automatic test_hit_clr();
        bus.Lvl_clr = 1'b1;
        @(negedge Clk);
        bus.Lvl_clr = 1'b0;
        n_tests++;
        if (bus.level !== 3'd0) begin
            n_fail++; $display("FAIL lvl_clr: got %0d expected 0", bus.level);
        end
        strobe(2, 1'b1, 1'b0, 1'b0);
        bus.Hit_clr = 1'b1;
        bus.Hit_ld  = 1'b1;
        @(negedge Clk);
        bus.Hit_clr = 1'b0;
        bus.Hit_ld  = 1'b0;
        strobe(3, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.level !== 3'd0) begin
            n_fail++; $display("FAIL hit_clr_beats_ld: got level %0d expected 0", bus.level);
        end
        strobe(1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.level !== 3'd1) begin
            n_fail++; $display("FAIL hit_after_clr: got level %0d expected 1", bus.level);
        end
        strobe(3, 1'b1, 1'b0, 1'b0);
        bus.Lvl_clr = 1'b1;
        bus.Hit_ld  = 1'b1;
        @(negedge Clk);
        bus.Lvl_clr = 1'b0;
        bus.Hit_ld  = 1'b0;
        n_tests++;
        if (bus.level !== 3'd0) begin
            n_fail++; $display("FAIL lvl_clr_beats_ld: got %0d expected 0", bus.level);
        end
    endtask

    task automatic test_t20_level_change();
        int c, f;
        c = 0; f = -1;
        strobe(3, 1'b1, 1'b0, 1'b0);
        bus.T20_en = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge Clk);
            if (bus.T20_out === 1'b1) begin
                c++;
                if (f < 0) f = k;
            end
            bus.Hit_ld = (k == 17);
        end
        bus.T20_en = 1'b0;
        n_tests++;
        if (c != 1 || f != 19 || bus.level !== 3'd1) begin
            n_fail++; $display("FAIL t20_level_change: got cnt=%0d first=%0d lvl=%0d expected 1 19 1",
                               c, f, bus.level);
        end
        @(negedge Clk);
    endtask

    task automatic test_scores();
        strobe(5, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (bus.p2_score !== 4'd5 || bus.winner !== 1'b0) begin
            n_fail++; $display("FAIL p2_fifth_ld: got p2=%0d winner=%0b expected 5 0",
                               bus.p2_score, bus.winner);
        end
        @(negedge Clk);
        n_tests++;
        if (bus.winner !== 1'b1 || bus.winner_id !== 1'b1 || bus.p1_score !== 4'd0) begin
            n_fail++; $display("FAIL p2_wins: got winner=%0b id=%0b p1=%0d expected 1 1 0",
                               bus.winner, bus.winner_id, bus.p1_score);
        end
        strobe(1, 1'b0, 1'b0, 1'b1);
        @(negedge Clk);
        n_tests++;
        if (bus.p2_score !== 4'd5 || bus.winner !== 1'b1) begin
            n_fail++; $display("FAIL p2_saturate: got p2=%0d winner=%0b expected 5 1",
                               bus.p2_score, bus.winner);
        end
        bus.P2_clr = 1'b1;
        bus.P2_ld  = 1'b1;
        @(negedge Clk);
        bus.P2_clr = 1'b0;
        bus.P2_ld  = 1'b0;
        n_tests++;
        if (bus.p2_score !== 4'd0) begin
            n_fail++; $display("FAIL p2_clr_beats_ld: got %0d expected 0", bus.p2_score);
        end
        @(negedge Clk);
        n_tests++;
        if (bus.winner !== 1'b0) begin
            n_fail++; $display("FAIL p2_winner_clear: got %0b expected 0", bus.winner);
        end
    endtask

    task automatic test_simultaneous();
        strobe(4, 1'b0, 1'b1, 1'b1);
        @(negedge Clk);
        n_tests++;
        if (bus.p1_score !== 4'd4 || bus.p2_score !== 4'd4 || bus.winner !== 1'b0) begin
            n_fail++; $display("FAIL both_at_4: got p1=%0d p2=%0d winner=%0b expected 4 4 0",
                               bus.p1_score, bus.p2_score, bus.winner);
        end
        strobe(1, 1'b0, 1'b1, 1'b1);
        @(negedge Clk);
        n_tests++;
        if (bus.p1_score !== 4'd5 || bus.p2_score !== 4'd5 ||
            bus.winner !== 1'b1 || bus.winner_id !== 1'b0) begin
            n_fail++; $display("FAIL tie_win: got p1=%0d p2=%0d winner=%0b id=%0b expected 5 5 1 0",
                               bus.p1_score, bus.p2_score, bus.winner, bus.winner_id);
        end
        bus.P1_clr = 1'b1;
        bus.P2_clr = 1'b1;
        @(negedge Clk);
        bus.P1_clr = 1'b0;
        bus.P2_clr = 1'b0;
        n_tests++;
        if (bus.p1_score !== 4'd0 || bus.p2_score !== 4'd0) begin
            n_fail++; $display("FAIL both_clr: got p1=%0d p2=%0d expected 0 0",
                               bus.p1_score, bus.p2_score);
        end
        @(negedge Clk);
        n_tests++;
        if (bus.winner !== 1'b0 || bus.winner_id !== 1'b0) begin
            n_fail++; $display("FAIL tie_winner_clear: got winner=%0b id=%0b expected 0 0",
                               bus.winner, bus.winner_id);
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_t5();
        test_level();
        test_hit_clr();
        test_t20_level_change();
        test_scores();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
